// File: rtl/vc_pkg.sv
// Shared victim-cache types: default widths, evict buffer entry layout, FSM states.
package vc_pkg;
    localparam int TAG_W = 44;
    localparam int IDX_W = 6;
    localparam int BLK_W = 512;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] index;
        logic [BLK_W-1:0] data;
    } evict_entry_t;

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} evb_state_t;
endpackage

// File: rtl/evict_match.sv
// Combinational {tag,index} compare against every buffered entry; one-hot result
// because coalescing keeps buffered keys unique.
module evict_match #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 44,
    parameter int IDX_W = 6
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][TAG_W-1:0] tags,
    input  logic [DEPTH-1:0][IDX_W-1:0] indexes,
    input  logic [TAG_W-1:0]            key_tag,
    input  logic [IDX_W-1:0]            key_index,
    output logic [DEPTH-1:0]            match
);
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i] == key_tag) && (indexes[i] == key_index);
        end
    end
endmodule

// File: rtl/evict_buffer.sv
// L1 eviction FIFO feeding the victim cache write port, with coalescing and flush.
// Define EVICT_FWD_EN to enable the registered lookup/forwarding probe.
module evict_buffer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = vc_pkg::TAG_W,
    parameter int IDX_W = vc_pkg::IDX_W,
    parameter int BLK_W = vc_pkg::BLK_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evict_valid,
    input  logic [TAG_W-1:0] evict_tag,
    input  logic [IDX_W-1:0] evict_index,
    input  logic [BLK_W-1:0] evict_data,
    output logic             evict_ready,
    input  logic             vc_ready,
    output logic             vc_write_en,
    output logic [TAG_W-1:0] vc_tag,
    output logic [IDX_W-1:0] vc_index,
    output logic [BLK_W-1:0] vc_data,
    input  logic             flush_req,
    output logic             flush_done,
    input  logic             lookup_en,
    input  logic [TAG_W-1:0] lookup_tag,
    input  logic [IDX_W-1:0] lookup_index,
    output logic             fwd_hit,
    output logic [BLK_W-1:0] fwd_data
);
    import vc_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;
    logic [DEPTH-1:0][BLK_W-1:0] data_q, data_d;
    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;
    evb_state_t                  state_q, state_d;
    logic                        flush_done_q, flush_done_d;

    logic [DEPTH-1:0] coal_match, head_mask, coal_vec;
    logic             pop, coal_hit, coal_wr, push_new;

    evict_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_coal_match (
        .valid     (valid_q),
        .tags      (tag_q),
        .indexes   (idx_q),
        .key_tag   (evict_tag),
        .key_index (evict_index),
        .match     (coal_match)
    );

    // A head entry leaving this cycle cannot absorb a coalesce; the push becomes a fresh entry.
    always_comb begin
        pop         = (count_q != '0) && vc_ready && (state_q != IDLE);
        evict_ready = (count_q != FULL) && (state_q != FLUSH);
        head_mask   = '0;
        head_mask[head_q] = pop;
        coal_vec    = coal_match & ~head_mask;
        coal_hit    = |coal_vec;
        coal_wr     = evict_valid && coal_hit && (state_q != FLUSH);
        push_new    = evict_valid && evict_ready && !coal_hit;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push_new) begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = evict_tag;
            idx_d[tail_q]   = evict_index;
            data_d[tail_q]  = evict_data;
            tail_d          = tail_q + PTR_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (coal_wr && coal_vec[i]) begin
                data_d[i] = evict_data;
            end
        end
        count_d = count_q + CNT_W'(push_new) - CNT_W'(pop);
    end

    // A flush that finds nothing left to drain goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_req) state_d = (count_d != '0) ? FLUSH : DONE;
                else if (push_new) state_d = DRAIN;
            end
            DRAIN: begin
                if (flush_req) state_d = (count_d != '0) ? FLUSH : DONE;
                else if (count_d == '0) state_d = IDLE;
            end
            FLUSH: begin
                if (count_d == '0) state_d = DONE;
            end
            DONE: begin
                state_d = (count_d != '0) ? DRAIN : IDLE;
            end
            default: state_d = IDLE;
        endcase
        flush_done_d = (state_d == DONE);
    end

`ifdef EVICT_FWD_EN
    logic [DEPTH-1:0] fwd_vec;
    logic [BLK_W-1:0] fwd_sel;
    logic             fwd_hit_q, fwd_hit_d;
    logic [BLK_W-1:0] fwd_data_q, fwd_data_d;

    evict_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .IDX_W(IDX_W)) u_fwd_match (
        .valid     (valid_q),
        .tags      (tag_q),
        .indexes   (idx_q),
        .key_tag   (lookup_tag),
        .key_index (lookup_index),
        .match     (fwd_vec)
    );

    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_vec[i]) fwd_sel |= data_q[i];
        end
        fwd_hit_d  = lookup_en && (|fwd_vec);
        fwd_data_d = lookup_en ? fwd_sel : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign fwd_hit  = fwd_hit_q;
    assign fwd_data = fwd_data_q;
`else
    logic unused_lookup;
    assign unused_lookup = ^{lookup_en, lookup_tag, lookup_index};
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            tag_q        <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            state_q      <= IDLE;
            flush_done_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign vc_write_en = pop;
    assign vc_tag      = tag_q[head_q];
    assign vc_index    = idx_q[head_q];
    assign vc_data     = data_q[head_q];
    assign flush_done  = flush_done_q;
endmodule

// File: doc/evict_buffer.md
Name: evict_buffer

Overview:
- Small FIFO between the L1 dcache eviction path and the victim cache write port.
- Captures dirty or clean lines evicted from L1 (physical tag, 6-bit index, 512-bit block) and drains them one per cycle into the victim cache.
- Decouples L1 refill timing from the victim cache's LRU write, and supports a flush sequence.
- Coalesces re-evictions of a line that is already buffered.

Parameters:
DEPTH, 4, number of buffered lines; power of two, 2..8
TAG_W, 44, physical tag width
IDX_W, 6, set index bits stored alongside the tag
BLK_W, 512, cache block width in bits

Ports:
clk  input  1  the clock
reset  input  1  asynchronous, active-high reset
evict_valid  input  1  L1 presents an evicted line this cycle
evict_tag  input  TAG_W  physical tag of the evicted line
evict_index  input  IDX_W  index bits of the evicted line
evict_data  input  BLK_W  evicted block
evict_ready  output  1  buffer can accept; a push occurs when evict_valid && evict_ready
vc_ready  input  1  victim cache can take a write this cycle
vc_write_en  output  1  write strobe to the victim cache
vc_tag  output  TAG_W  head entry tag
vc_index  output  IDX_W  head entry index
vc_data  output  BLK_W  head entry block
flush_req  input  1  single-cycle pulse: drain all entries
flush_done  output  1  single-cycle pulse when the flush completes
lookup_en  input  1  forwarding probe (optional feature)
lookup_tag  input  TAG_W  probe tag
lookup_index  input  IDX_W  probe index
fwd_hit  output  1  probe matched a buffered entry (registered)
fwd_data  output  BLK_W  matched block (registered)

Behaviour:
- Reset (async): pointers, count and entry valid bits = 0; FSM = IDLE. Outputs: evict_ready=1, vc_write_en=0, flush_done=0, fwd_hit=0; vc_tag/vc_index/vc_data/fwd_data = 0.
- Storage is a circular array. head_ptr and tail_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- evict_ready = (count != DEPTH) && state != FLUSH. It does not look ahead to a same-cycle pop, so a full buffer refuses a push even while draining.
- Coalesce: on a push whose {tag,index} equals a valid entry, that entry's data is overwritten in place. Pointers and count are unchanged. The push is accepted even when full.
- Coalescing into the head entry in the same cycle it pops: the pop wins. The new data is then pushed as a fresh entry.
- vc_tag/vc_index/vc_data always show the head entry. They are don't-care (held) when empty.
- vc_write_en = (count != 0) && vc_ready && state != IDLE. A pop occurs on vc_write_en: the head advances and count decrements.
- Simultaneous push (non-coalescing) and pop: count is unchanged and both pointers advance.
- Latency: a pushed line can reach vc_write_en no earlier than the next cycle; there is no same-cycle passthrough.
- FSM:
  - IDLE: count==0. A push moves to DRAIN.
  - DRAIN: pop whenever vc_ready. Go to IDLE when count reaches 0 with no push. flush_req moves to FLUSH.
  - FLUSH: pushes are blocked and pops continue. On count==0 go to DONE.
  - DONE: flush_done=1 for one cycle, then go to IDLE.
- flush_req in IDLE goes to DONE directly; flush_done pulses the next cycle.
- flush_req while in FLUSH or DONE is ignored.
- vc_ready held low stalls indefinitely. No timeout and no data loss.
- Reset mid-flush discards all entries and produces no flush_done.

Optional Feature:
- Macro EVICT_FWD_EN.
- Defined:
  - A lookup_en probe compares {lookup_tag,lookup_index} against all valid entries.
  - The next cycle, fwd_hit=1 and fwd_data = the matching block. Matching is unique because of coalescing.
  - An entry popping in the probe cycle still matches; the comparison uses pre-clock state.
- Undefined: fwd_hit and fwd_data are tied to 0 and the comparators are absent.

Decomposition:
- Shared package vc_pkg holds:
  - constants TAG_W=44, IDX_W=6, BLK_W=512
  - typedef evict_entry_t (valid, tag, index, data)
  - FSM enum evb_state_t {IDLE, DRAIN, FLUSH, DONE}
- One natural sub-module, evict_match: combinational {tag,index} compare across all entries, returning a one-hot match vector. It is used for both coalescing and forwarding.

Test Plan:
1. Reset, then push tag=0x1A, idx=3, data=0xAA.., with vc_ready=1 -> vc_write_en=1 exactly one cycle later with tag 0x1A/idx 3; count returns to 0; FSM ends in IDLE.
2. vc_ready=0 and 4 distinct pushes -> evict_ready=0 after the 4th. Then raise vc_ready -> 4 writes on consecutive cycles in push order, with the head pointer wrapping 3->0.
3. Buffer holds tag=0x5, idx=1, data=A; push tag=0x5, idx=1, data=B -> count unchanged; the drained entry carries data B.
4. 3 entries, vc_ready=1, flush_req pulse -> evict_ready=0 during the drain; flush_done pulses one cycle after the 3rd write. flush_req when empty -> flush_done on the next cycle.
5. With EVICT_FWD_EN: buffer tag=0x7, idx=2; probe the same -> fwd_hit=1 with the correct data the next cycle. Probe idx=3 -> fwd_hit=0.
6. Assert reset asynchronously mid-FLUSH with 2 entries -> all outputs return to reset values immediately; no vc_write_en and no flush_done afterwards.
